// File: rtl/ca_ctrl_pkg.sv
// Shared types and default constants for the CA stream sequencer.
// Optional report FIFO is selected with the CA_RPT_FIFO_EN macro.
package ca_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int          OFF_W_DEF    = 16;
  localparam logic [7:0]  PAD_WORD_DEF = 8'h00;

  typedef struct packed {
    logic [OFF_W_DEF-1:0] offset;
  } rpt_t;

endpackage

// File: rtl/ca_rpt_fifo.sv
// Report FIFO with a registered head; full capacity is DEPTH entries.
// Instantiated by ca_stream_ctrl only when CA_RPT_FIFO_EN is defined.
module ca_rpt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count, count_after_pop, count_nxt;

  assign full            = (count == (AW+1)'(DEPTH));
  assign rd_ptr_nxt      = rd_ptr + AW'(rd_en);
  assign count_after_pop = count - (AW+1)'(rd_en);
  assign count_nxt       = count_after_pop + (AW+1)'(wr_en);

  // NOTE: storage has no reset; only pointers, count and the head register do.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      // Head comes from the write port when the queue would otherwise be empty.
      if (count_after_pop == '0 && wr_en) rd_data <= wr_data;
      else if (count_after_pop != '0)     rd_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/ca_stream_ctrl.sv
// Stream sequencer for the 8-STE CA processor: flush, feed, drain, tag reports.
// Define CA_RPT_FIFO_EN to queue reports in a FIFO instead of a single register.
module ca_stream_ctrl
  import ca_ctrl_pkg::*;
#(
  parameter int         OFF_W     = OFF_W_DEF,
  parameter logic [7:0] PAD_WORD  = PAD_WORD_DEF,
  parameter int         FLUSH_CYC = 2,
  parameter int         RPT_LAT   = 2,
  parameter int         RPT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             ca_rst,
  output logic [7:0]       ca_word,
  input  logic             ca_rpt_bt,
  output logic             rpt_valid,
  output logic [OFF_W-1:0] rpt_offset,
  input  logic             rpt_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             gap_err,
  output logic [OFF_W-1:0] rpt_count
);

  localparam int RUN_LAT = RPT_LAT + 1;
  localparam int CNT_MAX = (FLUSH_CYC > RUN_LAT) ? FLUSH_CYC : RUN_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [OFF_W-1:0] off_cnt;
  logic             accept, flush_entry;
  logic             detect, push, pop, drop, rpt_full;
  logic [OFF_W-1:0] tail_off;
  logic [RPT_LAT-1:0] pipe_vld;
  logic [OFF_W-1:0]   pipe_off [RPT_LAT];

  assign accept      = s_ready & s_valid;
  assign flush_entry = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);
  assign ca_rst      = rst | (state == ST_FLUSH);
  assign busy        = (state == ST_FLUSH) || (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);

  // NOTE: next-state is defaulted before the case so no path leaves it unassigned.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FLUSH;
      ST_FLUSH: if (cnt == CNT_W'(FLUSH_CYC - 1)) state_nxt = ST_RUN;
      ST_RUN:   if (accept && s_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (cnt == CNT_W'(RUN_LAT - 1)) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_FLUSH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      s_ready   <= 1'b0;
      ca_word   <= PAD_WORD;
      off_cnt   <= '0;
      overflow  <= 1'b0;
      gap_err   <= 1'b0;
      rpt_count <= '0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == ST_RUN);
      ca_word <= accept ? s_data : PAD_WORD;
      if (state_nxt != state || !(state == ST_FLUSH || state == ST_DRAIN)) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);
      if (flush_entry) begin
        off_cnt   <= '0;
        overflow  <= 1'b0;
        gap_err   <= 1'b0;
        rpt_count <= '0;
      end else begin
        if (accept) off_cnt <= off_cnt + OFF_W'(1);
        if (state == ST_RUN && !accept) gap_err <= 1'b1;
        if (detect && rpt_count != '1) rpt_count <= rpt_count + OFF_W'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Offset pipe aligns each accepted word's offset with its ca_rpt_bt sample.
  always_ff @(posedge clk) begin
    if (rst) pipe_vld <= '0;
    else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < RPT_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_off[0] <= off_cnt;
    for (int i = 1; i < RPT_LAT; i++) pipe_off[i] <= pipe_off[i-1];
  end

  assign tail_off = pipe_off[RPT_LAT-1];
  assign detect   = pipe_vld[RPT_LAT-1] & ca_rpt_bt;
  assign pop      = rpt_valid & rpt_ready;
  assign push     = detect & (~rpt_full | pop);
  assign drop     = detect & rpt_full & ~pop;

`ifdef CA_RPT_FIFO_EN
  ca_rpt_fifo #(
    .WIDTH (OFF_W),
    .DEPTH (RPT_DEPTH)
  ) u_rpt_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (tail_off),
    .rd_en    (pop),
    .rd_valid (rpt_valid),
    .rd_data  (rpt_offset),
    .full     (rpt_full)
  );
`else
  assign rpt_full = rpt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_valid  <= 1'b0;
      rpt_offset <= '0;
    end else if (push) begin
      rpt_valid  <= 1'b1;
      rpt_offset <= tail_off;
    end else if (pop) begin
      rpt_valid  <= 1'b0;
    end
  end
`endif

endmodule
